if_prefetch: RTL

IF_PREFETCH -- requirements
Module: if_prefetch

---
 rtl/if_prefetch.sv | 120 ++++++++++++
 1 files changed

// File: rtl/if_prefetch.sv
// rtl/if_prefetch.sv - instruction prefetch queue with in-order memory fetch, redirect and stale-response drop
module if_prefetch #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic            clk,
  input  logic            RN,
  output logic            imem_req,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_gnt,
  input  logic            imem_rvalid,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            if_valid,
  output logic [XLEN-1:0] if_ir,
  output logic [XLEN-1:0] if_npc,
  input  logic            if_ready,
  output logic [3:0]      q_count,
  output logic            spur_err
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [XLEN-1:0] fpc_q, fpc_d;
  logic [XLEN-1:0] rpc_q, rpc_d;
  logic [3:0]      out_q, out_d;
  logic [3:0]      drop_q, drop_d;
  logic [3:0]      cnt_q, cnt_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW-1:0]   wr_q, wr_d;
  logic [XLEN-1:0] ir_q  [DEPTH];
  logic [XLEN-1:0] npc_q [DEPTH];
  logic            spur_q;
  logic            run_q;

  logic            grant;
  logic            rsp_ok;
  logic            rsp_drop;
  logic            push;
  logic            pop;
  logic [4:0]      occ;

  // Queued plus in-flight entries never exceed DEPTH, so a push always has room.
  assign occ       = {1'b0, cnt_q} + {1'b0, out_q};
  assign imem_req  = run_q && !redirect && (occ < 5'(DEPTH));
  assign imem_addr = fpc_q;
  assign grant     = imem_req && imem_gnt;

  assign rsp_ok    = imem_rvalid && (out_q != 4'd0);
  assign rsp_drop  = rsp_ok && (drop_q != 4'd0);
  assign push      = rsp_ok && (drop_q == 4'd0) && !redirect;

  assign if_valid  = (cnt_q != 4'd0);
  assign pop       = if_valid && if_ready;
  assign if_ir     = if_valid ? ir_q[rd_q] : '0;
  assign if_npc    = if_valid ? npc_q[rd_q] : '0;
  assign q_count   = cnt_q;
  assign spur_err  = spur_q;

  always_comb begin
    fpc_d  = fpc_q;
    rpc_d  = rpc_q;
    drop_d = drop_q;
    cnt_d  = cnt_q;
    rd_d   = rd_q;
    wr_d   = wr_q;
    out_d  = out_q + {3'b000, grant} - {3'b000, rsp_ok};
    if (redirect) begin
      // Everything still in flight belongs to the abandoned path.
      fpc_d  = redirect_pc;
      rpc_d  = redirect_pc;
      drop_d = out_q - {3'b000, rsp_ok};
      cnt_d  = 4'd0;
      rd_d   = '0;
      wr_d   = '0;
    end else begin
      if (grant)    fpc_d  = fpc_q + XLEN'(1);
      if (rsp_drop) drop_d = drop_q - 4'd1;
      if (push) begin
        rpc_d = rpc_q + XLEN'(1);
        wr_d  = wr_q + AW'(1);
      end
      if (pop) rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + {3'b000, push} - {3'b000, pop};
    end
  end

  always_ff @(posedge clk or negedge RN) begin
    if (!RN) begin
      fpc_q  <= '0;
      rpc_q  <= '0;
      out_q  <= 4'd0;
      drop_q <= 4'd0;
      cnt_q  <= 4'd0;
      rd_q   <= '0;
      wr_q   <= '0;
      spur_q <= 1'b0;
      run_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ir_q[i]  <= '0;
        npc_q[i] <= '0;
      end
    end else begin
      fpc_q  <= fpc_d;
      rpc_q  <= rpc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
      cnt_q  <= cnt_d;
      rd_q   <= rd_d;
      wr_q   <= wr_d;
      run_q  <= 1'b1;
      if (imem_rvalid && (out_q == 4'd0)) spur_q <= 1'b1;
      if (push) begin
        ir_q[wr_q]  <= imem_rdata;
        npc_q[wr_q] <= rpc_q + XLEN'(1);
      end
    end
  end

endmodule
